// File: rtl/rtc_stopwatch_ctrl.sv
// Stopwatch control FSM: button edge detect, holdoff, counter sequencing.
// Optional STOP_AT_MAX_EN: halt in STOP with sticky overflow at MAX_COUNT.
module rtc_stopwatch_ctrl #(
  parameter int          HOLDOFF_CYCLES = 4,
  parameter logic [23:0] MAX_COUNT      = 24'h595999,
  parameter int          HOLDOFF_W      = 8
) (
  input  logic        i_rtcclk,
  input  logic        i_reset,
  input  logic        i_startstop,
  input  logic        i_lapreset,
  input  logic [23:0] i_count,
  output logic        o_countenb,
  output logic        o_countinit,
  output logic        o_latchcount,
  output logic [1:0]  o_state,
  output logic        o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 r_ss_prev;
  logic                 r_lr_prev;
  logic [HOLDOFF_W-1:0] r_holdoff;

  logic w_hold_clr;
  logic w_ss_ev;
  logic w_lr_ev;
  logic w_any_ev;
  logic w_at_max;
  logic w_ovf;
  logic w_enb;

  assign w_hold_clr = (r_holdoff == '0);
  assign w_ss_ev    = i_startstop & ~r_ss_prev & w_hold_clr;
  // start/stop wins a tie; the lap/reset edge is dropped
  assign w_lr_ev    = i_lapreset & ~r_lr_prev & w_hold_clr & ~w_ss_ev;
  assign w_any_ev   = w_ss_ev | w_lr_ev;

`ifdef STOP_AT_MAX_EN
  logic r_overflow;

  assign w_at_max = ((r_state == S_RUN) || (r_state == S_LAP)) &&
                    (i_count == MAX_COUNT);
  assign w_ovf    = r_overflow;

  always_ff @(posedge i_rtcclk) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
    end else if (w_at_max) begin
      r_overflow <= 1'b1;
    end else if ((r_state == S_STOP) && (w_next == S_IDLE)) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_overflow = r_overflow;
`else
  logic w_unused;

  assign w_at_max   = 1'b0;
  assign w_ovf      = 1'b0;
  assign o_overflow = 1'b0;
  assign w_unused   = ^{i_count, MAX_COUNT};
`endif

  always_ff @(posedge i_rtcclk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_ss_prev <= 1'b1;
      r_lr_prev <= 1'b1;
      r_holdoff <= '0;
    end else begin
      r_state   <= w_next;
      r_ss_prev <= i_startstop;
      r_lr_prev <= i_lapreset;
      if (w_any_ev) begin
        r_holdoff <= HOLDOFF_W'(HOLDOFF_CYCLES);
      end else if (!w_hold_clr) begin
        r_holdoff <= r_holdoff - HOLDOFF_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_at_max) begin
      w_next = S_STOP;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_ss_ev) w_next = S_RUN;
        end
        S_RUN: begin
          if (w_ss_ev)      w_next = S_STOP;
          else if (w_lr_ev) w_next = S_LAP;
        end
        S_LAP: begin
          if (w_ss_ev)      w_next = S_STOP;
          else if (w_lr_ev) w_next = S_RUN;
        end
        S_STOP: begin
          if (w_ss_ev && !w_ovf) w_next = S_RUN;
          else if (w_lr_ev)      w_next = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_enb        = 1'b0;
    o_countinit  = 1'b0;
    o_latchcount = 1'b1;
    unique case (r_state)
      S_IDLE: o_countinit  = 1'b1;
      S_RUN:  w_enb        = 1'b1;
      S_LAP: begin
        w_enb        = 1'b1;
        o_latchcount = 1'b0;
      end
      S_STOP: w_enb        = 1'b0;
    endcase
  end

  // terminal-count gate holds the counter on the cycle it reaches MAX
  assign o_countenb = w_enb & ~w_at_max;
  assign o_state    = r_state;

endmodule

// File: tb/tb_rtc_stopwatch_ctrl.sv
// Directed bench for rtc_stopwatch_ctrl with a BCD counter model in the loop.
// Expected values go into a scoreboard queue and are drained after each step.
module tb_rtc_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ss;
  logic        lr;
  logic [23:0] cnt = 24'h0;
  logic        ld = 1'b0;
  logic [23:0] ld_val = 24'h0;
  logic        enb;
  logic        init;
  logic        latch;
  logic [1:0]  st;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [23:0] exp;
  } exp_t;

  exp_t q[$];

  rtc_stopwatch_ctrl dut (
    .i_rtcclk     (clk),
    .i_reset      (rst),
    .i_startstop  (ss),
    .i_lapreset   (lr),
    .i_count      (cnt),
    .o_countenb   (enb),
    .o_countinit  (init),
    .o_latchcount (latch),
    .o_state      (st),
    .o_overflow   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  lim [6];
    logic        c;
    lim[0] = 4'd9; lim[1] = 4'd9; lim[2] = 4'd9;
    lim[3] = 4'd5; lim[4] = 4'd9; lim[5] = 4'd5;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == lim[i]) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // External BCD counter driven by the DUT controls
  always @(posedge clk) begin
    if (ld)        cnt <= ld_val;
    else if (init) cnt <= 24'h0;
    else if (enb)  cnt <= bcd_inc(cnt);
  end

  function automatic logic [23:0] obs(input int s);
    case (s)
      0:       return {22'h0, st};
      1:       return {23'h0, enb};
      2:       return {23'h0, init};
      3:       return {23'h0, latch};
      4:       return {23'h0, ovf};
      default: return cnt;
    endcase
  endfunction

  task automatic push(input string t, input int s, input logic [23:0] e);
    exp_t x;
    x.tag = t;
    x.sig = s;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [23:0] o;
    while (q.size() > 0) begin
      x = q.pop_front();
      o = obs(x.sig);
      n_tests++;
      assert (o === x.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ss();
    ss = 1'b1; tick(1); ss = 1'b0;
  endtask

  task automatic pulse_lr();
    lr = 1'b1; tick(1); lr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ss = 1'b1; lr = 1'b0;
    tick(2);
    push("rst_state", 0, 24'd0);
    push("rst_init",  2, 24'd1);
    push("rst_enb",   1, 24'd0);
    push("rst_latch", 3, 24'd1);
    push("rst_ovf",   4, 24'd0);
    drain();
    rst = 1'b0;
    tick(3);
    push("held_no_event", 0, 24'd0);
    drain();

    ss = 1'b0; tick(1);
    pulse_ss();
    push("start_state", 0, 24'd1);
    push("start_enb",   1, 24'd1);
    drain();
    tick(19);
    ss = 1'b1; tick(1); ss = 1'b0;
    push("stop_state", 0, 24'd3);
    push("stop_count", 5, 24'h000020);
    drain();
    tick(6);
    push("stop_hold", 5, 24'h000020);
    drain();

    pulse_ss();
    push("resume_state", 0, 24'd1);
    push("resume_count", 5, 24'h000020);
    drain();
    tick(6);
    pulse_lr();
    push("lap_state", 0, 24'd2);
    push("lap_latch", 3, 24'd0);
    push("lap_enb",   1, 24'd1);
    drain();
    tick(6);
    pulse_lr();
    push("unlap_state", 0, 24'd1);
    push("unlap_latch", 3, 24'd1);
    push("unlap_count", 5, 24'h000034);
    drain();

    tick(6);
    pulse_ss();
    tick(1);
    pulse_ss();
    push("holdoff_state", 0, 24'd3);
    push("holdoff_count", 5, 24'h000041);
    drain();
    tick(6);
    ss = 1'b1; lr = 1'b1; tick(1); ss = 1'b0; lr = 1'b0;
    push("tie_state", 0, 24'd1);
    push("tie_init",  2, 24'd0);
    drain();

    tick(6);
    pulse_ss();
    tick(6);
    pulse_lr();
    push("clr_state", 0, 24'd0);
    push("clr_init",  2, 24'd1);
    push("clr_count", 5, 24'h000048);
    drain();
    tick(1);
    push("clr_count0", 5, 24'h000000);
    drain();

    tick(6);
    pulse_ss();
    tick(3);
    rst = 1'b1; tick(1); rst = 1'b0;
    push("midrst_state", 0, 24'd0);
    push("midrst_init",  2, 24'd1);
    push("midrst_enb",   1, 24'd0);
    drain();
    tick(1);
    push("midrst_count", 5, 24'h000000);
    drain();

    tick(6);
    pulse_ss();
    ld = 1'b1; ld_val = 24'h595995; tick(1); ld = 1'b0;
    tick(4);
    push("max_count", 5, 24'h595999);
`ifdef STOP_AT_MAX_EN
    push("max_enb",   1, 24'd0);
    push("max_state", 0, 24'd1);
    drain();
    tick(1);
    push("ovf_state", 0, 24'd3);
    push("ovf_flag",  4, 24'd1);
    drain();
    tick(10);
    push("ovf_hold", 5, 24'h595999);
    drain();
    pulse_ss();
    push("ovf_ss_ign", 0, 24'd3);
    drain();
    tick(6);
    pulse_lr();
    push("ovf_idle",  0, 24'd0);
    push("ovf_clear", 4, 24'd0);
    drain();
`else
    push("max_enb", 1, 24'd1);
    drain();
    tick(1);
    push("wrap_count", 5, 24'h000000);
    push("wrap_state", 0, 24'd1);
    push("wrap_ovf",   4, 24'd0);
    drain();
    tick(6);
    pulse_ss();
    tick(6);
    pulse_lr();
    push("wrap_idle", 0, 24'd0);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_stopwatch_ctrl.md
Name: rtc_stopwatch_ctrl

Overview:
- Control FSM for the stopwatch. Sequences the 24-bit BCD counter (digits mm:ss.hh, rollover at 'h595999) by driving its count-enable, count-init and latch-count inputs.
- Inputs are start/stop and lap/reset button levels from the trigger-detection stage.
- Implements idle, run, lap-freeze and stop modes with edge detection, priority resolution and a re-trigger holdoff.

Parameters:
- HOLDOFF_CYCLES, 4: clocks after an accepted button event during which further button edges are ignored; 0 disables holdoff.
- MAX_COUNT, 24'h595999: terminal counter value. Used only when STOP_AT_MAX_EN is defined.
- HOLDOFF_W, 8: width of the holdoff down-counter; HOLDOFF_CYCLES must be < 2**HOLDOFF_W.

Ports:
- i_rtcclk  input  1  system clock, rising-edge active
- i_reset  input  1  synchronous, active-high reset
- i_startstop  input  1  start/stop button level, synchronous to i_rtcclk
- i_lapreset  input  1  lap/reset button level, synchronous to i_rtcclk
- i_count  input  24  current BCD count fed back from the counter
- o_countenb  output  1  counter increment enable
- o_countinit  output  1  counter clear (synchronous init)
- o_latchcount  output  1  1 = counter output register tracks the count; 0 = display frozen
- o_state  output  2  encoded state: 0 IDLE, 1 RUN, 2 LAP, 3 STOP
- o_overflow  output  1  sticky "hit MAX_COUNT" flag

Behaviour:
- Single clock domain. Reset is synchronous, active-high, sampled on the i_rtcclk rising edge; i_reset has priority over all other inputs.
- Reset values:
  - state=IDLE, holdoff counter=0, o_overflow=0.
  - Previous-sample registers for both buttons = 1, so a button held through reset does not generate an event.
- Edge detect: an event is button=1 now and 0 at the previous posedge. The event is accepted only if the holdoff counter is 0. Previous-sample registers update every clock, including during holdoff.
- Accepting any event loads the holdoff counter with HOLDOFF_CYCLES. The counter decrements by 1 per clock while nonzero and saturates at 0.
- Simultaneous start/stop and lap/reset events: start/stop wins; lap/reset is discarded and not queued.
- Latency: the state register updates on the same posedge that samples the accepted edge. Outputs are a combinational decode of the state register, so they change with the state.
- State transitions and outputs (o_countenb / o_countinit / o_latchcount):
  - IDLE (0/1/1): start/stop -> RUN; lap/reset ignored.
  - RUN (1/0/1): start/stop -> STOP; lap/reset -> LAP.
  - LAP (1/0/0): counting continues, display frozen. lap/reset -> RUN (display resumes live); start/stop -> STOP.
  - STOP (0/0/1): start/stop -> RUN (resumes from held count, no clear); lap/reset -> IDLE (clears counter, clears o_overflow).
- Without STOP_AT_MAX_EN, the counter wraps 'h595999 -> 0 freely in RUN and LAP, and the state is unaffected.
- o_state encoding is fixed as listed above.
- Reset mid-run: the next posedge gives IDLE, o_countinit=1, o_countenb=0; the counter clears one posedge later.

Optional Feature:
- STOP_AT_MAX_EN defined:
  - In RUN or LAP, when i_count==MAX_COUNT, o_countenb is forced 0 combinationally, so the counter holds at MAX_COUNT and never wraps.
  - On that posedge the state goes to STOP and o_overflow is set to 1.
  - o_overflow stays 1 until reset or the STOP->IDLE transition.
  - A button event on the same posedge is ignored.
  - In STOP with o_overflow=1, start/stop is ignored.
- STOP_AT_MAX_EN undefined: the comparator is not built, o_overflow is tied 0, and the counter wraps normally.

Test Plan:
1. Hold i_reset=1 for 2 clocks with i_startstop=1, then release (button stays high) -> state=IDLE, o_countinit=1, o_countenb=0, o_latchcount=1, and no event fires after reset.
2. From IDLE, pulse i_startstop 0->1 for 1 clock -> o_state=1, o_countenb=1 at that posedge; after 20 clocks i_count='h000020; a second pulse gives o_state=3, count holds at 'h000020.
3. In RUN, pulse i_lapreset -> o_state=2, o_latchcount=0, o_countenb=1; pulse again after ≥HOLDOFF_CYCLES clocks -> o_state=1, o_latchcount=1.
4. In RUN, pulse i_startstop, then pulse again 2 clocks later (HOLDOFF_CYCLES=4) -> second pulse ignored, o_state stays 3. Pulse i_startstop and i_lapreset on the same clock from STOP -> o_state=1 (start/stop wins).
5. From STOP, pulse i_lapreset -> o_state=0, o_countinit=1; next clock i_count=0.
6. With STOP_AT_MAX_EN, run until i_count='h595999 -> o_countenb=0 the same cycle, then o_state=3 and o_overflow=1; count stays 'h595999 for 10 clocks; i_startstop is ignored; i_lapreset gives IDLE and o_overflow=0. Without the macro, the count wraps to 0 and o_overflow stays 0.
